// File: rtl/edib_m57_tx_scheduler.sv
// -----------------------------------------------------------------------------
// edib_m57_tx_scheduler
//
// Round-robin scheduler that shares one EDIB M57 serial transmitter among
// N_CH requesters. It picks a requester, latches that channel's word, length
// and speed, and pulses the transmitter start. It then waits for the end of
// the frame, holds an inter-frame gap and arbitrates again.
//
// Ports
//   Clk, Rst            clock; synchronous active-high reset
//   Req[N_CH]           per-channel request level, held until Done/Err
//   ReqData[16*N_CH]    channel i word at [16i+15:16i]
//   ReqLen[16*N_CH]     channel i DataLength at [16i+15:16i]
//   ReqSpeed[N_CH]      channel i speed select
//   Gnt[N_CH]           one-hot grant, held from LOAD until frame end
//   Done[N_CH]          1-cycle pulse: frame for channel i completed
//   Err[N_CH]           1-cycle pulse: channel i rejected or aborted
//   M57In, DataLength,
//   Speed               transmitter operands, stable from LOAD to next LOAD
//   TxStart             1-cycle transmitter start pulse
//   TxBusy, TxFinished  transmitter status (TxFinished: rising edge used)
//   SchedBusy           high whenever the FSM is not IDLE
//
// Optional build macro: EDIB_SCHED_TIMEOUT_EN
//   When defined, a 24-bit watchdog runs in WAIT_BUSY/WAIT_DONE and aborts
//   the frame with an Err pulse after TO_CYC cycles. When undefined, the FSM
//   waits for TxFinished with no time limit.
// -----------------------------------------------------------------------------
module edib_m57_tx_scheduler #(
  parameter int          N_CH    = 4,
  parameter int          IFG_CYC = 288,
  parameter logic [15:0] LEN_MAX = 16'd512,
  parameter logic [23:0] TO_CYC  = 24'd1_000_000
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [N_CH-1:0]     Req,
  input  logic [16*N_CH-1:0]  ReqData,
  input  logic [16*N_CH-1:0]  ReqLen,
  input  logic [N_CH-1:0]     ReqSpeed,
  output logic [N_CH-1:0]     Gnt,
  output logic [N_CH-1:0]     Done,
  output logic [N_CH-1:0]     Err,
  output logic [15:0]         M57In,
  output logic [15:0]         DataLength,
  output logic                Speed,
  output logic                TxStart,
  input  logic                TxBusy,
  input  logic                TxFinished,
  output logic                SchedBusy
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int GW = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ARB       = 3'd1;
  localparam logic [2:0] LOAD      = 3'd2;
  localparam logic [2:0] START     = 3'd3;
  localparam logic [2:0] WAIT_BUSY = 3'd4;
  localparam logic [2:0] WAIT_DONE = 3'd5;
  localparam logic [2:0] GAP       = 3'd6;

  logic [2:0]      stateReg, stateNext;
  logic [PW-1:0]   ptrReg, selReg;
  logic [GW-1:0]   gapCntReg;
  logic            finPrevReg;
  logic [N_CH-1:0] gntReg, doneReg, errReg;
  logic [15:0]     m57InReg, dataLengthReg;
  logic            speedReg, txStartReg, schedBusyReg;

  // Per-channel views of the packed request buses.
  logic [15:0] chData [N_CH];
  logic [15:0] chLen  [N_CH];
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign chData[gi] = ReqData[16*gi +: 16];
    assign chLen[gi]  = ReqLen[16*gi +: 16];
  end

  // Round-robin pick: scan from Ptr+N_CH down to Ptr+1 so the last hit,
  // i.e. the one closest after Ptr, is what remains.
  logic          pickValid;
  logic [PW-1:0] pickIdx;
  logic [PW-1:0] candIdx;
  int            cand;
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    candIdx   = '0;
    cand      = 0;
    for (int k = N_CH; k >= 1; k--) begin
      cand    = (int'(ptrReg) + k) % N_CH;
      candIdx = PW'(cand);
      if (Req[candIdx]) begin
        pickValid = 1'b1;
        pickIdx   = candIdx;
      end
    end
  end

  logic [15:0]     pickLen;
  logic            lenBad;
  logic [N_CH-1:0] pickOneHot, selOneHot;
  assign pickLen    = chLen[pickIdx];
  assign lenBad     = (pickLen == 16'd0) || (pickLen > LEN_MAX);
  assign pickOneHot = {{(N_CH-1){1'b0}}, 1'b1} << pickIdx;
  assign selOneHot  = {{(N_CH-1){1'b0}}, 1'b1} << selReg;

  logic inWait, finRise, gapLast, wdHit;
  assign inWait  = (stateReg == WAIT_BUSY) || (stateReg == WAIT_DONE);
  assign finRise = TxFinished && !finPrevReg;
  assign gapLast = (gapCntReg == GW'(IFG_CYC - 1));

`ifdef EDIB_SCHED_TIMEOUT_EN
  logic [23:0] wdCntReg;
  // Counter is zero on the first WAIT_BUSY cycle, so the abort lands
  // TO_CYC cycles after entering WAIT_BUSY.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wdCntReg <= '0;
    end else if (inWait) begin
      wdCntReg <= wdCntReg + 24'd1;
    end else begin
      wdCntReg <= '0;
    end
  end
  assign wdHit = inWait && (wdCntReg == TO_CYC - 24'd1);
`else
  logic unusedToCyc;
  assign unusedToCyc = ^TO_CYC;
  assign wdHit       = 1'b0;
`endif

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:      if (|Req) stateNext = ARB;
      ARB: begin
        if (!pickValid)  stateNext = IDLE;   // request withdrawn meanwhile
        else if (lenBad) stateNext = GAP;
        else             stateNext = LOAD;
      end
      LOAD:      stateNext = START;
      START:     stateNext = WAIT_BUSY;
      // A finish edge arriving with (or before) busy still completes the frame.
      WAIT_BUSY: begin
        if (finRise || wdHit) stateNext = GAP;
        else if (TxBusy)      stateNext = WAIT_DONE;
      end
      WAIT_DONE: if (finRise || wdHit) stateNext = GAP;
      GAP:       if (gapLast) stateNext = (|Req) ? ARB : IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stateReg      <= IDLE;
      ptrReg        <= '0;
      selReg        <= '0;
      gapCntReg     <= '0;
      finPrevReg    <= 1'b0;
      gntReg        <= '0;
      doneReg       <= '0;
      errReg        <= '0;
      m57InReg      <= '0;
      dataLengthReg <= '0;
      speedReg      <= 1'b0;
      txStartReg    <= 1'b0;
      schedBusyReg  <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      schedBusyReg <= (stateNext != IDLE);
      txStartReg   <= (stateNext == START);
      finPrevReg   <= TxFinished;
      doneReg      <= '0;
      errReg       <= '0;
      gapCntReg    <= (stateReg == GAP) ? gapCntReg + GW'(1) : '0;

      case (stateReg)
        ARB: begin
          if (pickValid) begin
            selReg <= pickIdx;
            if (lenBad) begin
              errReg <= pickOneHot;
              ptrReg <= pickIdx;
            end else begin
              gntReg        <= pickOneHot;
              m57InReg      <= chData[pickIdx];
              dataLengthReg <= pickLen;
              speedReg      <= ReqSpeed[pickIdx];
            end
          end
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (finRise) begin
            doneReg <= selOneHot;
            gntReg  <= '0;
            ptrReg  <= selReg;
          end else if (wdHit) begin
            errReg  <= selOneHot;
            gntReg  <= '0;
            ptrReg  <= selReg;
          end
        end
        default: ;
      endcase
    end
  end

  assign Gnt        = gntReg;
  assign Done       = doneReg;
  assign Err        = errReg;
  assign M57In      = m57InReg;
  assign DataLength = dataLengthReg;
  assign Speed      = speedReg;
  assign TxStart    = txStartReg;
  assign SchedBusy  = schedBusyReg;

endmodule
